// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle control FSM for a simple processor datapath. It owns the PC and
// the instruction register, fetches one instruction at a time over a req/ack
// instruction-memory handshake, decodes it into datapath controls and strobes
// reg_write once per retired instruction.
//
// Optional build feature, selected by the macro PERF_COUNTERS_EN:
//   defined   -> cycle_count / instr_count are live 32-bit counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// state_dbg exposes the FSM state encoding for observation.

module multicycle_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        alu_src,
    output logic        op_select,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
    output logic [2:0]  state_dbg
);

    // Fetch handshake: imem_req is raised on entry to FETCH and stays high,
    // with imem_addr (= pc) stable, until the cycle in which imem_ack is seen
    // at a rising edge; that edge captures imem_rdata and drops imem_req.
    // imem_ack outside FETCH is ignored.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SHIMM = 6'h01;
    localparam logic [5:0] OP_LDC   = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Timer counts no-ack FETCH cycles; the last allowed value is one short
    // of the limit so that imem_req is high for exactly FETCH_TIMEOUT cycles.
    localparam logic [7:0] TIMER_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state;
    logic [7:0] fetch_timer;

    assign imem_addr = pc;
    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign state_dbg = state;

    // Sequencer FSM: state, PC, IR, fetch timer and all registered controls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= 32'h0000_0000;
            fetch_timer <= 8'd0;
            imem_req    <= 1'b0;
            alu_src     <= 1'b0;
            op_select   <= 1'b0;
            alu_op      <= 4'h0;
            reg_write   <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        ir          <= imem_rdata;
                        fetch_timer <= 8'd0;
                        imem_req    <= 1'b0;
                        state       <= S_DECODE;
                    end else if (fetch_timer == TIMER_LAST) begin
                        fetch_timer <= 8'd0;
                        imem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        state       <= S_FAULT;
                    end else begin
                        fetch_timer <= fetch_timer + 8'd1;
                    end
                end

                S_DECODE: begin
                    case (ir[31:26])
                        OP_RTYPE: begin
                            alu_src   <= 1'b0;
                            op_select <= 1'b0;
                            alu_op    <= ir[3:0];
                            state     <= S_EXECUTE;
                        end
                        OP_SHIMM: begin
                            alu_src   <= 1'b1;
                            op_select <= 1'b0;
                            alu_op    <= ir[3:0];
                            state     <= S_EXECUTE;
                        end
                        OP_LDC: begin
                            alu_src   <= 1'b0;
                            op_select <= 1'b1;
                            alu_op    <= 4'h0;
                            state     <= S_EXECUTE;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end
                        default: begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                            state       <= S_FAULT;
                        end
                    endcase
                end

                S_EXECUTE: begin
                    // Raise the write strobe so it is high during WRITEBACK only.
                    reg_write <= 1'b1;
                    state     <= S_WRITEBACK;
                end

                S_WRITEBACK: begin
                    reg_write <= 1'b0;
                    pc        <= pc + 32'd4;
                    imem_req  <= 1'b1;
                    state     <= S_FETCH;
                end

                S_HALTED, S_FAULT: begin
                    // Terminal until reset; controls keep their last values.
                    imem_req  <= 1'b0;
                    reg_write <= 1'b0;
                end

                default: begin
                    imem_req  <= 1'b0;
                    reg_write <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    // Performance counters: active cycles and retired instructions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (state != S_IDLE && state != S_HALTED && state != S_FAULT) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state == S_WRITEBACK) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer. Two instances share every input: dut
// uses RESET_PC = 0, dut_w uses RESET_PC = 32'hFFFF_FFFC to observe PC wrap.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_multicycle_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        imem_req, alu_src, op_select, reg_write, halted, fault;
    logic [31:0] imem_addr, pc, ir, cycle_count, instr_count;
    logic [5:0]  opcode, funct;
    logic [3:0]  alu_op;
    logic [1:0]  fault_cause;
    logic [2:0]  state_dbg;

    logic        w_imem_req, w_alu_src, w_op_select, w_reg_write, w_halted, w_fault;
    logic [31:0] w_imem_addr, w_pc, w_ir, w_cycle_count, w_instr_count;
    logic [5:0]  w_opcode, w_funct;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_fault_cause;
    logic [2:0]  w_state_dbg;

    multicycle_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .ir(ir), .opcode(opcode), .funct(funct),
        .alu_src(alu_src), .op_select(op_select), .alu_op(alu_op),
        .reg_write(reg_write), .halted(halted), .fault(fault),
        .fault_cause(fault_cause), .cycle_count(cycle_count),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    multicycle_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(16)) dut_w (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(w_pc), .ir(w_ir), .opcode(w_opcode), .funct(w_funct),
        .alu_src(w_alu_src), .op_select(w_op_select), .alu_op(w_alu_op),
        .reg_write(w_reg_write), .halted(w_halted), .fault(w_fault),
        .fault_cause(w_fault_cause), .cycle_count(w_cycle_count),
        .instr_count(w_instr_count), .state_dbg(w_state_dbg)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: expected fetch addresses ----------------
    logic [31:0] exp_q[$];
    logic        req_prev = 1'b0;
    int          rw_total = 0;

    always @(negedge clk) begin
        if (imem_req && !req_prev) begin
            if (exp_q.size() == 0)
                check_val("fetch_unexpected", 32'(exp_q.size()), 32'd1);
            else
                check_val("fetch_addr", imem_addr, exp_q.pop_front());
        end
        if (reg_write) rw_total++;
        req_prev = imem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check_val({tag, "_req"}, 32'(imem_req), 32'd0);
        check_val({tag, "_pc"}, pc, 32'h0000_0000);
        check_val({tag, "_addr"}, imem_addr, 32'h0000_0000);
        check_val({tag, "_ir"}, ir, 32'h0000_0000);
        check_val({tag, "_ctrl"}, {26'd0, alu_src, op_select, alu_op}, 32'd0);
        check_val({tag, "_rw"}, 32'(reg_write), 32'd0);
        check_val({tag, "_status"}, {28'd0, halted, fault, fault_cause}, 32'd0);
        check_val({tag, "_cyc"}, cycle_count, 32'd0);
        check_val({tag, "_ins"}, instr_count, 32'd0);
        check_val({tag, "_w_pc"}, w_pc, 32'hFFFF_FFFC);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_seq(input logic [31:0] first_addr, input string tag);
        exp_q.push_back(first_addr);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_start_req"}, 32'(imem_req), 32'd1);
    endtask

    // Called on a falling edge with the DUT in FETCH; returns on the falling
    // edge at which the next fetch request is visible.
    task automatic run_instr(input logic [31:0] word, input int waits, input logic e_src,
                             input logic e_sel, input logic [3:0] e_op, input string tag);
        logic [31:0] a0;
        int cyc;
        int rw;
        a0 = imem_addr;
        cyc = 0;
        rw = 0;
        exp_q.push_back(a0 + 32'd4);
        check_val({tag, "_req"}, 32'(imem_req), 32'd1);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            cyc++;
            check_val({tag, "_addr_hold"}, imem_addr, a0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        cyc++;
        imem_ack = 1'b0;
        imem_rdata = 32'hA5A5_A5A5;
        check_val({tag, "_ir"}, ir, word);
        check_val({tag, "_opcode"}, 32'(opcode), 32'(word[31:26]));
        check_val({tag, "_funct"}, 32'(funct), 32'(word[5:0]));
        check_val({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        while (!imem_req && cyc < waits + 12) begin
            if (reg_write) begin
                rw++;
                check_val({tag, "_alu_src"}, 32'(alu_src), 32'(e_src));
                check_val({tag, "_op_select"}, 32'(op_select), 32'(e_sel));
                check_val({tag, "_alu_op"}, 32'(alu_op), 32'(e_op));
            end
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'(4 + waits));
        check_val({tag, "_rw_count"}, 32'(rw), 32'd1);
        check_val({tag, "_pc_next"}, pc, a0 + 32'd4);
    endtask

    // Feeds a terminating word (HALT or illegal) and checks the sticky state.
    task automatic run_term(input logic [31:0] word, input logic e_halt, input logic e_fault,
                            input logic [1:0] e_cause, input string tag);
        logic [31:0] a0;
        int reqs;
        int rw0;
        a0 = pc;
        rw0 = rw_total;
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check_val({tag, "_halted"}, 32'(halted), 32'(e_halt));
        check_val({tag, "_fault"}, 32'(fault), 32'(e_fault));
        check_val({tag, "_cause"}, 32'(fault_cause), 32'(e_cause));
        check_val({tag, "_pc"}, pc, a0);
        reqs = 0;
        repeat (4) begin
            imem_ack = 1'b1;
            imem_rdata = 32'h0000_0001;
            @(negedge clk);
            if (imem_req) reqs++;
        end
        imem_ack = 1'b0;
        check_val({tag, "_no_req"}, 32'(reqs), 32'd0);
        check_val({tag, "_ir_kept"}, ir, word);
        check_val({tag, "_no_rw"}, 32'(rw_total), 32'(rw0));
        check_val({tag, "_pc_kept"}, pc, a0);
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int cnt;
        int rw0;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;

        // A: reset values, IDLE holds without start
        do_reset();
        check_reset_vals("rst");
        repeat (3) @(negedge clk);
        check_val("idle_no_req", 32'(imem_req), 32'd0);
        check_val("idle_pc", pc, 32'd0);

        // B: R-type (no wait), shift-imm (3 waits), then HALT at pc=8
        start_seq(32'h0000_0000, "b");
        run_instr(32'h0000_0003, 0, 1'b0, 1'b0, 4'h3, "rtype");
        run_instr(32'h0400_0002, 3, 1'b1, 1'b0, 4'h2, "shimm");
        check_val("pre_halt_pc", pc, 32'h0000_0008);
        run_term(32'hFC00_0000, 1'b1, 1'b0, 2'b00, "halt");
        check_val("halt_opcode", 32'(opcode), 32'h3F);
        check_val("halt_ctrl_kept", {26'd0, alu_src, op_select, alu_op}, {26'd0, 1'b1, 1'b0, 4'h2});
`ifdef PERF_COUNTERS_EN
        exp_cyc = 32'd13;
        exp_ins = 32'd2;
`else
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
`endif
        check_val("halt_cyc_frozen", cycle_count, exp_cyc);
        check_val("halt_ins", instr_count, exp_ins);

        // C: load constant, PC wrap on dut_w, then illegal opcode 0x15
        do_reset();
        check_val("c_w_addr", w_imem_addr, 32'hFFFF_FFFC);
        start_seq(32'h0000_0000, "c");
        run_instr(32'h0800_0007, 0, 1'b0, 1'b1, 4'h0, "ldc");
        check_val("wrap_pc", w_pc, 32'h0000_0000);
        check_val("wrap_addr", w_imem_addr, 32'h0000_0000);
        check_val("wrap_req", 32'(w_imem_req), 32'd1);
        run_term(32'h5400_0000, 1'b0, 1'b1, 2'b01, "illegal");
        check_val("illegal_sel_kept", 32'(op_select), 32'd1);

        // D: fetch timeout with no ack
        do_reset();
        start_seq(32'h0000_0000, "d");
        rw0 = rw_total;
        cnt = 0;
        while (imem_req && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_val("timeout_req_cycles", 32'(cnt), 32'd16);
        check_val("timeout_fault", 32'(fault), 32'd1);
        check_val("timeout_cause", 32'(fault_cause), 32'h2);
        check_val("timeout_halted", 32'(halted), 32'd0);
        repeat (3) @(negedge clk);
        check_val("timeout_req_low", 32'(imem_req), 32'd0);
        check_val("timeout_no_rw", 32'(rw_total), 32'(rw0));

        // E: reset mid-fetch, then 15-wait fetches must not time out
        do_reset();
        start_seq(32'h0000_0000, "e");
        repeat (5) @(negedge clk);
        check_val("mid_req_high", 32'(imem_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b1;
        start_seq(32'h0000_0000, "e2");
        run_instr(32'h0000_000C, 15, 1'b0, 1'b0, 4'hC, "wait15a");
        run_instr(32'h0400_0001, 15, 1'b1, 1'b0, 4'h1, "wait15b");
        check_val("wait15_no_fault", 32'(fault), 32'd0);

        // F: three zero-wait instructions, counter check
        do_reset();
        repeat (3) @(negedge clk);
        start_seq(32'h0000_0000, "f");
        run_instr(32'h0000_000A, 0, 1'b0, 1'b0, 4'hA, "f1");
        run_instr(32'h0400_0025, 0, 1'b1, 1'b0, 4'h5, "f2");
        run_instr(32'h0800_FFFF, 0, 1'b0, 1'b1, 4'h0, "f3");
`ifdef PERF_COUNTERS_EN
        exp_cyc = 32'd12;
        exp_ins = 32'd3;
`else
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
`endif
        check_val("perf_cycles", cycle_count, exp_cyc);
        check_val("perf_instrs", instr_count, exp_ins);
        check_val("f_pc", pc, 32'h0000_000C);

        do_reset();
        check_val("fetch_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
